// File: rtl/fcs_pkg.sv
// Shared parameters, FSM state type and the single-bit CRC-16 step used by the
// FCS generator.
package fcs_pkg;
  localparam int GEN_WIDTH    = 17;
  localparam int Rem_WIDTH    = GEN_WIDTH - 1;
  localparam int Max_IN_WIDTH = 1024;
  localparam int Min_IN_WIDTH = 64;
  localparam int CNT_WIDTH    = $clog2(Max_IN_WIDTH);
  localparam logic [GEN_WIDTH-1:0] POLY = 17'h11021;

  typedef enum logic [1:0] {IDLE, SHIFT_IN, SHIFT_OUT} state_t;

  // One LFSR step: feedback is the outgoing MSB xor the incoming frame bit.
  function automatic logic [Rem_WIDTH-1:0] crc_step(input logic [Rem_WIDTH-1:0] crc,
                                                     input logic din);
    logic fb;
    fb = crc[Rem_WIDTH-1] ^ din;
    return {crc[Rem_WIDTH-2:0], 1'b0} ^ (fb ? POLY[Rem_WIDTH-1:0] : '0);
  endfunction
endpackage

// File: rtl/fcs_crc_lfsr.sv
// Remainder register: clear, absorb one frame bit, or shift right for serial output.
module fcs_crc_lfsr
  import fcs_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 step_i,
  input  logic                 din_i,
  input  logic                 shift_i,
  output logic [Rem_WIDTH-1:0] crc_o,
  output logic [Rem_WIDTH-1:0] crc_next_o
);
  logic [Rem_WIDTH-1:0] crc_q, crc_d, base;

  // Clear and step coincide on frame acceptance: the first bit steps from zero.
  always_comb begin
    base  = clr_i ? '0 : crc_q;
    crc_d = crc_q;
    if (step_i)       crc_d = crc_step(base, din_i);
    else if (shift_i) crc_d = {1'b0, crc_q[Rem_WIDTH-1:1]};
    else if (clr_i)   crc_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o      = crc_q;
  assign crc_next_o = crc_d;
endmodule

// File: rtl/fcs_top.sv
// Serial CRC-16-CCITT frame check sequence generator: absorbs a serial frame MSB
// first, then emits the 16-bit remainder LSB first with fully registered outputs.
// Handshake: Valid_Data is a one-cycle start strobe honoured only while Busy is
// low; Valid_OUT qualifies OUT for exactly 16 cycles, Done marks the last one.
module fcs_top
  import fcs_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Valid_Data,
  input  logic [CNT_WIDTH-1:0] Data_Size,
  input  logic                 Input_Data,
  output logic                 OUT,
  output logic                 Done,
  output logic                 Valid_OUT,
  output logic                 Busy,
  output state_t               dbg_state_o
);
  state_t               state_q;
  logic [CNT_WIDTH-1:0] size_q, bit_cnt_q, bit_cnt_inc;
  logic [3:0]           out_cnt_q;
  logic                 out_q, done_q, valid_q, busy_q;
  logic                 accept, last_in, lfsr_step, lfsr_shift;
  logic [Rem_WIDTH-1:0] crc, crc_next;

  // The 10-bit Data_Size cannot exceed 1023, so only the lower bound needs a check.
  assign accept      = (state_q == IDLE) && Valid_Data &&
                       (Data_Size >= CNT_WIDTH'(Min_IN_WIDTH));
  assign bit_cnt_inc = bit_cnt_q + 1'b1;
  assign last_in     = (state_q == SHIFT_IN) && (bit_cnt_inc == size_q);
  assign lfsr_step   = accept || (state_q == SHIFT_IN);
  assign lfsr_shift  = (state_q == SHIFT_OUT);

  fcs_crc_lfsr u_lfsr (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (accept),
    .step_i     (lfsr_step),
    .din_i      (Input_Data),
    .shift_i    (lfsr_shift),
    .crc_o      (crc),
    .crc_next_o (crc_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      size_q    <= '0;
      bit_cnt_q <= '0;
      out_cnt_q <= '0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_q    <= Data_Size;
            bit_cnt_q <= CNT_WIDTH'(1);
            out_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          bit_cnt_q <= bit_cnt_inc;
          if (last_in) begin
            // OUT leaves a flop, so preload it with bit 0 of the final remainder.
            out_q     <= crc_next[0];
            valid_q   <= 1'b1;
            out_cnt_q <= '0;
            state_q   <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          if (out_cnt_q == 4'd15) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            out_q     <= crc_next[0];
            out_cnt_q <= out_cnt_q + 1'b1;
            done_q    <= (out_cnt_q == 4'd14);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OUT         = out_q;
  assign Done        = done_q;
  assign Valid_OUT   = valid_q;
  assign Busy        = busy_q;
  assign dbg_state_o = state_q;

  logic unused_crc;
  assign unused_crc = ^crc;
endmodule

// File: tb/tb_fcs_top.sv
// Bench for fcs_top: random and directed frames against a long-division CRC model.
module tb_fcs_top;
  import fcs_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, Valid_Data, Input_Data;
  logic [9:0] Data_Size;
  logic       OUT, Done, Valid_OUT, Busy;
  state_t     dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        fr[0:1023];

  fcs_top dut (
    .CLK         (CLK),
    .RST         (RST),
    .Valid_Data  (Valid_Data),
    .Data_Size   (Data_Size),
    .Input_Data  (Input_Data),
    .OUT         (OUT),
    .Done        (Done),
    .Valid_OUT   (Valid_OUT),
    .Busy        (Busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Polynomial long division of frame*x^16 by G(x), plain bit-at-a-time subtraction.
  function automatic logic [15:0] ref_crc(input int n);
    logic [16:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < n + 16; i++) begin
      b = (i < n) ? fr[i] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic load64(input logic [63:0] v);
    for (int i = 0; i < 64; i++) fr[i] = v[63-i];
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) fr[i] = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver ----------------
  // Cycle k: outputs sampled at the negedge inside it, inputs driven for its closing posedge.
  task automatic send_frame(input int n, input bit chained, input int s_in, input int s_out);
    exp_q.push_back(ref_crc(n));
    for (int k = 1; k <= n; k++) begin
      if (!(chained && k == 1)) @(negedge CLK);
      if (k == 1) check("busy_c1", Busy, 0);
      if (k == 2) check("busy_c2", Busy, 1);
      if (k == n) check("valid_before_end", Valid_OUT, 0);
      Valid_Data = (k == 1) || (k == s_in);
      Data_Size  = (k == 1) ? 10'(n) : 10'($urandom_range(64, 1023));
      Input_Data = fr[k-1];
    end
    for (int j = n + 1; j <= n + 16; j++) begin
      @(negedge CLK);
      check("valid_out", Valid_OUT, 1);
      check("done_pos", Done, (j == n + 16) ? 1 : 0);
      check("busy_out", Busy, 1);
      Valid_Data = (j == s_out);
      Data_Size  = 10'd64;
      Input_Data = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    Valid_Data = 1'b0;
    check("busy_fall", Busy, 0);
    check("valid_fall", Valid_OUT, 0);
    check("done_fall", Done, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  int          idx = 0;
  logic [15:0] word = '0;

  always @(negedge CLK) begin
    if (RST) begin
      idx = 0;
    end else begin
      if (Valid_OUT) begin
        if (idx < 16) word[idx] = OUT;
        idx++;
      end
      if (Done) begin
        check("fcs_len", idx, 16);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done with no frame pending expected none");
        end else begin
          check("fcs", word, exp_q.pop_front());
        end
        idx = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, act;
    RST = 1'b1; Valid_Data = 1'b0; Data_Size = '0; Input_Data = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", Busy, 0);
    check("rst_valid", Valid_OUT, 0);
    check("rst_done", Done, 0);
    check("rst_out", OUT, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;

    load64(64'h0000_0000_0040_0056); send_frame(64, 0, 0, 72);
    load64(64'h0);                   send_frame(64, 0, 0, 0);
    load64(64'h1);                   send_frame(64, 0, 30, 0);

    // Longest frame with stray strobes mid-frame and mid-output, then an immediate frame.
    fill_random(1023); send_frame(1023, 0, 500, 1030);
    fill_random(100);  send_frame(100, 1, 0, 0);

    // Reset at input bit 30 aborts the frame.
    fill_random(200);
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      Valid_Data = (k == 1);
      Data_Size  = 10'd200;
      Input_Data = fr[k-1];
      RST        = (k == 30);
    end
    @(negedge CLK);
    RST = 1'b0; Valid_Data = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_valid", Valid_OUT, 0);
    check("abort_out", OUT, 0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    act = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done || Valid_OUT || Busy) act++;
    end
    check("abort_quiet", act, 0);
    fill_random(80); send_frame(80, 0, 0, 0);

    // Too-short frames are refused.
    foreach (Data_Size[i]) ;
    for (int s = 0; s < 2; s++) begin
      @(negedge CLK);
      Valid_Data = 1'b1;
      Data_Size  = (s == 0) ? 10'd10 : 10'd63;
      @(negedge CLK);
      Valid_Data = 1'b0;
      repeat (3) begin
        @(negedge CLK);
        check("reject_busy", Busy, 0);
      end
    end

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(64, 300);
      fill_random(n);
      send_frame(n, i[0], $urandom_range(2, n), n + $urandom_range(1, 16));
    end

    repeat (3) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule
